// File: rtl/key_gen.sv
// -----------------------------------------------------------------------------
// key_gen -- DES key schedule (FIPS 46-3), fully combinational with one
// register stage.
//
// Ports
//   clk                 in   1   single clock, all state updates on rising edge
//   rst_n               in   1   synchronous active-low reset
//   KEY                 in  64   DES key, DES bit 1 = KEY[63], bit 64 = KEY[0]
//   r_key1 .. r_key16   out 48   registered round keys K1..K16,
//                                DES bit 1 of each key = r_keyN[47]
//
// Latency is one cycle; a new key may be presented every cycle. The only
// state in the block is the 16 x 48 output register bank.
// -----------------------------------------------------------------------------
module key_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] KEY,
  output logic [47:0] r_key1,
  output logic [47:0] r_key2,
  output logic [47:0] r_key3,
  output logic [47:0] r_key4,
  output logic [47:0] r_key5,
  output logic [47:0] r_key6,
  output logic [47:0] r_key7,
  output logic [47:0] r_key8,
  output logic [47:0] r_key9,
  output logic [47:0] r_key10,
  output logic [47:0] r_key11,
  output logic [47:0] r_key12,
  output logic [47:0] r_key13,
  output logic [47:0] r_key14,
  output logic [47:0] r_key15,
  output logic [47:0] r_key16
);

  // Permuted choice 1: entry n is the DES key bit feeding bit n+1 of {C0,D0}.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: entry n is the {Ci,Di} bit feeding key bit n+1.
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Cumulative left-rotation of C/D after each round (running sum of the
  // per-round shifts 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1). Using the running
  // total lets every round be derived straight from C0/D0 instead of a
  // 16-deep chain of rotations.
  localparam int SHIFT_CUM [16] = '{
    1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28
  };

  logic [27:0] w_c0;
  logic [27:0] w_d0;
  logic [47:0] w_key [16];

  // Parity bits (DES bits 8,16,...,64) take no part in the schedule.
  logic w_unused_parity;
  assign w_unused_parity = ^{KEY[56], KEY[48], KEY[40], KEY[32],
                             KEY[24], KEY[16], KEY[8],  KEY[0]};

  genvar gi;
  genvar gj;

  // PC-1: DES bit n of the key lives at KEY[64-n]; DES bit p of a 28-bit
  // half lives at half[28-p].
  generate
    for (gi = 0; gi < 28; gi++) begin : g_pc1
      localparam int SRC_C = 64 - PC1[gi];
      localparam int SRC_D = 64 - PC1[gi + 28];
      assign w_c0[27 - gi] = KEY[SRC_C];
      assign w_d0[27 - gi] = KEY[SRC_D];
    end
  endgenerate

  // Rotation and PC-2 folded into pure wiring: after a cumulative left
  // rotation by S, DES position p of Ci holds position ((p-1+S) mod 28)+1
  // of C0 (same for D). Each key bit is therefore a fixed wire from C0/D0.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_round
      for (gj = 0; gj < 48; gj++) begin : g_pc2
        localparam int T = PC2[gj];
        if (T <= 28) begin : g_from_c
          localparam int POS = ((T - 1 + SHIFT_CUM[gi]) % 28) + 1;
          assign w_key[gi][47 - gj] = w_c0[28 - POS];
        end else begin : g_from_d
          localparam int POS = ((T - 29 + SHIFT_CUM[gi]) % 28) + 1;
          assign w_key[gi][47 - gj] = w_d0[28 - POS];
        end
      end
    end
  endgenerate

  // Single register stage; reset takes priority over loading.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key1  <= '0;
      r_key2  <= '0;
      r_key3  <= '0;
      r_key4  <= '0;
      r_key5  <= '0;
      r_key6  <= '0;
      r_key7  <= '0;
      r_key8  <= '0;
      r_key9  <= '0;
      r_key10 <= '0;
      r_key11 <= '0;
      r_key12 <= '0;
      r_key13 <= '0;
      r_key14 <= '0;
      r_key15 <= '0;
      r_key16 <= '0;
    end else begin
      r_key1  <= w_key[0];
      r_key2  <= w_key[1];
      r_key3  <= w_key[2];
      r_key4  <= w_key[3];
      r_key5  <= w_key[4];
      r_key6  <= w_key[5];
      r_key7  <= w_key[6];
      r_key8  <= w_key[7];
      r_key9  <= w_key[8];
      r_key10 <= w_key[9];
      r_key11 <= w_key[10];
      r_key12 <= w_key[11];
      r_key13 <= w_key[12];
      r_key14 <= w_key[13];
      r_key15 <= w_key[14];
      r_key16 <= w_key[15];
    end
  end

endmodule

// File: tb/tb_key_gen.sv
// -----------------------------------------------------------------------------
// tb_key_gen -- self-checking bench for key_gen.
// Table-driven known vectors, hand-written sequences for sampling/latency and
// mid-operation reset, and a random key sweep against a bit-array DES key
// schedule model that rotates C/D round by round.
// -----------------------------------------------------------------------------
module tb_key_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] KEY;
  logic [47:0] k_out [16];

  always #5 clk = ~clk;

  key_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .KEY     (KEY),
    .r_key1  (k_out[0]),
    .r_key2  (k_out[1]),
    .r_key3  (k_out[2]),
    .r_key4  (k_out[3]),
    .r_key5  (k_out[4]),
    .r_key6  (k_out[5]),
    .r_key7  (k_out[6]),
    .r_key8  (k_out[7]),
    .r_key9  (k_out[8]),
    .r_key10 (k_out[9]),
    .r_key11 (k_out[10]),
    .r_key12 (k_out[11]),
    .r_key13 (k_out[12]),
    .r_key14 (k_out[13]),
    .r_key15 (k_out[14]),
    .r_key16 (k_out[15])
  );

  int checks = 0;
  int errors = 0;

  // Reference tables, DES 1-based bit numbering.
  int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int sh_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] exp_k [16];

  // Model: unpack to DES bit arrays, apply PC-1, then per round rotate C and
  // D one position at a time and apply PC-2.
  task automatic compute_model(input logic [63:0] key);
    logic kb [1:64];
    logic c  [1:28];
    logic d  [1:28];
    logic cd [1:56];
    logic tc;
    logic td;
    for (int t = 1; t <= 64; t++) kb[t] = key[64 - t];
    for (int j = 1; j <= 28; j++) begin
      c[j] = kb[pc1_t[j - 1]];
      d[j] = kb[pc1_t[j + 27]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < sh_t[r]; s++) begin
        tc = c[1];
        td = d[1];
        for (int j = 1; j < 28; j++) begin
          c[j] = c[j + 1];
          d[j] = d[j + 1];
        end
        c[28] = tc;
        d[28] = td;
      end
      for (int j = 1; j <= 28; j++) begin
        cd[j]      = c[j];
        cd[j + 28] = d[j];
      end
      for (int j = 1; j <= 48; j++) exp_k[r][48 - j] = cd[pc2_t[j - 1]];
    end
  endtask

  task automatic check48(input string name, input logic [47:0] act, input logic [47:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Compare all 16 outputs to the model (loaded) or to zero (reset).
  task automatic check_all(input string tag, input logic loaded);
    for (int i = 0; i < 16; i++)
      check48($sformatf("%s_k%0d", tag, i + 1), k_out[i], loaded ? exp_k[i] : 48'h0);
  endtask

  typedef struct {
    logic        rst_n;
    logic [63:0] key;
    bit          use_const;
    logic [47:0] e1;
    logic [47:0] e2;
    logic [47:0] e16;
  } vec_t;

  vec_t vecs [8];

  localparam logic [63:0] KNOWN = 64'h133457799BBCDFF1;

  initial begin
    vecs[0] = '{1'b0, KNOWN, 1'b1, 48'h0, 48'h0, 48'h0};
    vecs[1] = '{1'b0, KNOWN, 1'b1, 48'h0, 48'h0, 48'h0};
    vecs[2] = '{1'b1, KNOWN, 1'b1, 48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'hCB3D8B0E17F5};
    vecs[3] = '{1'b1, 64'h0101010101010101, 1'b1, 48'h0, 48'h0, 48'h0};
    vecs[4] = '{1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};
    vecs[5] = '{1'b1, 64'h0, 1'b1, 48'h0, 48'h0, 48'h0};
    vecs[6] = '{1'b1, 64'h8FFB3DD99EEA2CC8, 1'b0, 48'h0, 48'h0, 48'h0};
    vecs[7] = '{1'b1, 64'hFEFEFEFEFEFEFEFE, 1'b1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF};

    rst_n = 1'b0;
    KEY   = KNOWN;

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      rst_n = vecs[v].rst_n;
      KEY   = vecs[v].key;
      @(posedge clk);
      #1;
      compute_model(vecs[v].key);
      check_all($sformatf("vec%0d", v), vecs[v].rst_n);
      if (vecs[v].use_const) begin
        check48($sformatf("vec%0d_const_k1", v),  k_out[0],  vecs[v].e1);
        check48($sformatf("vec%0d_const_k2", v),  k_out[1],  vecs[v].e2);
        check48($sformatf("vec%0d_const_k16", v), k_out[15], vecs[v].e16);
      end
      $display("vec %0d rst_n=%b key=%h k1=%h k16=%h", v, vecs[v].rst_n, vecs[v].key, k_out[0], k_out[15]);
    end

    // Sampling/latency: a mid-cycle KEY change must not reach the outputs
    @(negedge clk);
    rst_n = 1'b1;
    KEY   = 64'h0;
    @(posedge clk);
    #1;
    check_all("lat_zero", 1'b0);
    @(negedge clk);
    KEY = KNOWN;
    #1;
    check48("lat_mid_k1",  k_out[0],  48'h0);
    check48("lat_mid_k16", k_out[15], 48'h0);
    @(posedge clk);
    #1;
    check48("lat_edge_k1", k_out[0], 48'h1B02EFFC7072);
    compute_model(KNOWN);
    check_all("lat_edge", 1'b1);
    $display("latency seq key=%h k1=%h", KEY, k_out[0]);

    // Reset mid-operation: no asynchronous effect, clears at edge, reloads
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check48("rst_async_k1", k_out[0], 48'h1B02EFFC7072);
    @(posedge clk);
    #1;
    check_all("rst_mid", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_reload", 1'b1);
    $display("reset seq key=%h k1=%h k2=%h", KEY, k_out[0], k_out[1]);

    // Random sweep with a throwaway KEY glitch before the real value
    for (int n = 0; n < 64; n++) begin
      logic [63:0] rk;
      logic        rr;
      rk = {$urandom, $urandom};
      rr = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      rst_n = rr;
      KEY   = {$urandom, $urandom};
      #2;
      KEY   = rk;
      @(posedge clk);
      #1;
      compute_model(rk);
      check_all($sformatf("rand%0d", n), rr);
      $display("rand %0d rst_n=%b key=%h k1=%h k16=%h", n, rr, rk, k_out[0], k_out[15]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_gen.md
KEY_GEN -- requirements
Module: key_gen

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 KEY  input  64  DES cipher key.
- Bit numbering: DES bit 1 = KEY[63], DES bit 64 = KEY[0].
- Includes 8 parity bits: DES bits 8,16,...,64.
REQ-005 r_key1 .. r_key16  output  48 each  registered DES round keys K1..K16.
- DES bit 1 of each key = r_keyN[47].
- No other ports SHALL exist.

Function
REQ-006 The block SHALL compute the standard DES key schedule per FIPS 46-3 from KEY.
REQ-007 PC-1 SHALL select 56 bits from KEY, forming C0 (28 bits, first half) and D0 (28 bits, second half).
- Parity bits 8,16,...,64 SHALL be ignored.
REQ-008 For round i = 1..16, Ci and Di SHALL each be Ci-1/Di-1 rotated left (toward DES bit 1) by the shift count for that round.
- Shift counts, rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (28 total).
- Therefore C16 = C0 and D16 = D0.
REQ-009 Ki SHALL be PC-2 applied to the 56-bit concatenation {Ci, Di}, yielding 48 bits.
REQ-010 Computation of all 16 keys from KEY SHALL be combinational, feeding one register stage.
- On every rising clk edge with rst_n high, all r_keyN SHALL load the keys derived from the KEY value present at that edge.
- Latency: 1 cycle; throughput: a new key every cycle.
REQ-011 Outputs SHALL change only at rising clk edges, never combinationally with KEY.
REQ-012 If KEY changes between edges, only its value at the sampling edge SHALL matter.
REQ-013 No handshake exists; the block SHALL have no state other than the 16x48 output registers.

Reset
REQ-014 When rst_n is low at a rising clk edge, all r_key1..r_key16 SHALL become 48'h0, regardless of KEY.
REQ-015 Outputs SHALL be undefined after power-up until the first reset edge.
REQ-016 Reset SHALL dominate loading.
- Asserting rst_n mid-operation clears all outputs at the next edge.
- The first edge with rst_n high loads KEY.
REQ-017 rst_n SHALL have no asynchronous effect; outputs hold their value between edges even if rst_n falls.

Verification
REQ-018 Bench scenarios:
- Reset: hold rst_n=0 for 2 edges with KEY=64'h133457799BBCDFF1 -> all 16 outputs 48'h0.
- Known vector: rst_n=1, KEY=64'h133457799BBCDFF1, one edge -> r_key1=48'h1B02EFFC7072, r_key2=48'h79AED9DBC9E5, r_key16=48'hCB3D8B0E17F5.
- Parity-only key: KEY=64'h0101010101010101 -> all 16 outputs 48'h0 (parity ignored).
- All-ones key: KEY=64'hFFFFFFFFFFFFFFFF -> all 16 outputs 48'hFFFFFFFFFFFF; KEY=64'h0 -> all 48'h0.
- Latency/sampling: change KEY from 64'h0 to 64'h133457799BBCDFF1 mid-cycle -> outputs stay 0 until the next rising edge, then r_key1=48'h1B02EFFC7072.
- Reset mid-operation: after loading 64'h133457799BBCDFF1, drive rst_n=0 for one edge -> all outputs 0; release -> keys reload on the next edge.
- Also run a random KEY sweep against a reference DES model for all 16 keys.
- Also apply KEY=64'h8FFB3DD99EEA2CC8 and compare all round keys to the model.
